// File: rtl/serial_paralelo_rx_multi.sv
// Multi-lane serial-to-parallel receiver with comma-based lock and idle detection.
// All lanes share one bit counter and thus one symbol boundary; each lane runs its own lock FSM.
module serial_paralelo_rx_multi #(
  parameter int               LANES    = 1,
  parameter int               SYM_W    = 8,
  parameter logic [SYM_W-1:0] COMMA    = 8'hBC,
  parameter logic [SYM_W-1:0] IDLE_SYM = 8'h7C,
  parameter int               LOCK_CNT = 4
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic [LANES-1:0]         data_in,
  input  logic                     resync,
  output logic [LANES*SYM_W-1:0]   data_out,
  output logic [LANES-1:0]         valid,
  output logic [LANES-1:0]         active,
  output logic [LANES-1:0]         idle
);

  // state  | meaning
  // HUNT   | searching for the first COMMA
  // COUNT  | seen 1..LOCK_CNT-1 consecutive COMMAs
  // LOCKED | aligned; data and idle symbols are delivered
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int CW = (SYM_W > 1) ? $clog2(SYM_W) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int SW = SYM_W - 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SYM_W - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CNT);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          shift_q [LANES];
  logic [SW-1:0]          shift_d [LANES];
  state_t                 state_q [LANES];
  state_t                 state_d [LANES];
  logic [LW-1:0]          lock_q  [LANES];
  logic [LW-1:0]          lock_d  [LANES];
  logic [SYM_W-1:0]       sym     [LANES];
  logic [LANES*SYM_W-1:0] data_out_q, data_out_d;
  logic [LANES-1:0]       valid_q, valid_d;
  logic [LANES-1:0]       idle_q, idle_d;
  logic [LANES-1:0]       active_q, active_d;
  logic                   boundary;

  always_comb begin
    boundary   = (cnt_q == CNT_LAST);
    cnt_d      = boundary ? '0 : cnt_q + CW'(1);
    data_out_d = data_out_q;
    valid_d    = '0;
    idle_d     = idle_q;
    active_d   = active_q;

    for (int l = 0; l < LANES; l++) begin
      // only the newest SYM_W-1 bits are ever needed; the incoming bit completes the symbol
      shift_d[l] = SW'({shift_q[l], data_in[l]});
      sym[l]     = {shift_q[l], data_in[l]};
      state_d[l] = state_q[l];
      lock_d[l]  = lock_q[l];

      if (resync) begin
        state_d[l] = HUNT;
        lock_d[l]  = '0;
        idle_d[l]  = 1'b0;
      end else if (boundary) begin
        idle_d[l] = 1'b0;
        unique case (state_q[l])
          HUNT: begin
            if (sym[l] == COMMA) begin
              lock_d[l]  = LW'(1);
              state_d[l] = (LOCK_CNT == 1) ? LOCKED : COUNT;
            end
          end
          COUNT: begin
            if (sym[l] == COMMA) begin
              lock_d[l] = lock_q[l] + LW'(1);
              if ((lock_q[l] + LW'(1)) == LOCK_LAST) begin
                state_d[l] = LOCKED;
              end
            end else begin
              lock_d[l]  = '0;
              state_d[l] = HUNT;
            end
          end
          LOCKED: begin
            if (sym[l] == IDLE_SYM) begin
              idle_d[l] = 1'b1;
            end else if (sym[l] != COMMA) begin
              data_out_d[l*SYM_W +: SYM_W] = sym[l];
              valid_d[l]                   = 1'b1;
            end
          end
          default: begin
            state_d[l] = HUNT;
            lock_d[l]  = '0;
          end
        endcase
      end

      active_d[l] = (state_d[l] == LOCKED);
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      cnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= '0;
      idle_q     <= '0;
      active_q   <= '0;
      for (int l = 0; l < LANES; l++) begin
        shift_q[l] <= '0;
        state_q[l] <= HUNT;
        lock_q[l]  <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      idle_q     <= idle_d;
      active_q   <= active_d;
      for (int l = 0; l < LANES; l++) begin
        shift_q[l] <= shift_d[l];
        state_q[l] <= state_d[l];
        lock_q[l]  <= lock_d[l];
      end
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign idle     = idle_q;
  assign active   = active_q;

endmodule

// File: doc/serial_paralelo_rx_multi.md
SERIAL_PARALELO_RX_MULTI -- requirements
Module: serial_paralelo_rx_multi

Parameters
REQ-001 SHALL have parameter LANES, default 1: number of independent serial lanes.
REQ-002 SHALL have parameter SYM_W, default 8: symbol width in bits.
REQ-003 SHALL have parameter COMMA, default 8'hBC: alignment symbol.
REQ-004 SHALL have parameter IDLE_SYM, default 8'h7C: idle symbol.
REQ-005 SHALL have parameter LOCK_CNT, default 4: consecutive COMMA symbols required for lock, range 1..15.

Interface
REQ-006 SHALL have clk_4f  input  1: the single clock; all logic on its rising edge.
REQ-007 SHALL have reset  input  1: synchronous, active-low reset.
REQ-008 SHALL have data_in  input  LANES: one serial bit per lane per cycle, MSB of each symbol first.
REQ-009 SHALL have resync  input  1: single-cycle strobe forcing all lanes back to HUNT.
REQ-010 SHALL have data_out  output  LANES*SYM_W: lane l symbol at [l*SYM_W +: SYM_W].
REQ-011 SHALL have valid  output  LANES: per-lane one-cycle data strobe.
REQ-012 SHALL have active  output  LANES: per-lane lock indication.
REQ-013 SHALL have idle  output  LANES: per-lane idle indication.

Function
REQ-014 SHALL keep a bit counter cnt, width $clog2(SYM_W), shared by all lanes, counting 0..SYM_W-1 and wrapping to 0; it increments every cycle out of reset.
REQ-015 SHALL shift each lane's bit into a per-lane shift register every cycle; the bit taken at cnt==0 becomes bit SYM_W-1 of the symbol.
REQ-016 SHALL define the symbol boundary as the edge where cnt==SYM_W-1; the assembled symbol is {shift[SYM_W-2:0], data_in[l]}.
REQ-017 SHALL update valid, idle, active, data_out and the per-lane FSM only at symbol boundaries; valid is cleared on every non-boundary edge.
REQ-018 SHALL implement a per-lane FSM with states HUNT, COUNT and LOCKED, plus a lock counter of width $clog2(LOCK_CNT+1).
REQ-019 SHALL behave in HUNT as follows: on symbol==COMMA, set lock counter to 1 and go to COUNT; if LOCK_CNT==1, go directly to LOCKED instead. Any other symbol stays in HUNT.
REQ-020 SHALL behave in COUNT as follows: on COMMA, increment the lock counter and go to LOCKED when it reaches LOCK_CNT; on any other symbol, clear the counter and return to HUNT.
REQ-021 SHALL stay in LOCKED until resync or reset; COMMA symbols in LOCKED are consumed with valid=0 and idle=0.
REQ-022 SHALL drive active[l]=1 exactly when lane l is in LOCKED; active rises on the boundary edge completing the LOCK_CNT-th consecutive COMMA.
REQ-023 SHALL, in LOCKED when the symbol equals IDLE_SYM, set idle[l]=1, keep valid[l]=0 and leave data_out unchanged; idle holds until the next boundary.
REQ-024 SHALL, in LOCKED when the symbol is neither COMMA nor IDLE_SYM, load the lane's data_out slice, pulse valid[l] for one cycle and clear idle[l].
REQ-025 SHALL keep valid=0 and idle=0 in HUNT and COUNT; data_out holds its last value.
REQ-026 SHALL apply resync=1 on any edge as follows: all FSMs go to HUNT, lock counters clear, and active, idle and valid clear; cnt and the shift registers are unaffected.
REQ-027 SHALL give reset priority over resync; resync has priority over boundary processing on the same edge.
REQ-028 SHALL operate all lanes independently, each with its own FSM, while sharing the symbol boundary.

Reset
REQ-029 SHALL, on reset==0 at an edge, clear cnt, all shift registers, data_out, valid, idle and active to 0 and place every FSM in HUNT.
REQ-030 SHALL apply reset mid-symbol or mid-lock immediately; the next symbol boundary is the SYM_W-th edge after release.

Verification
REQ-031 SHALL cover lock: defaults; after reset release, send 4x 8'hBC -> active=1 on edge 32 and not on edge 24; valid stays 0 throughout.
REQ-032 SHALL cover idle and data: after lock, send 8'h7C -> idle=1 for 8 cycles, valid=0; then send 8'h5A -> data_out=8'h5A, valid=1 for one cycle, idle=0.
REQ-033 SHALL cover broken comma run: BC, BC, BC, 00, then BC x4 -> active stays 0 until the 4th BC of the second run completes.
REQ-034 SHALL cover resync: lock, then pulse resync mid-symbol -> active=0 the next cycle; the lane relocks only after 4 more consecutive BC.
REQ-035 SHALL cover reset mid-operation: lock, drive reset=0 for one cycle mid-symbol -> all outputs 0; sending 8'h5A then yields no valid.
REQ-036 SHALL cover multi-lane: LANES=2; lane0 receives BC x4 then 8'h11, lane1 receives 8'h00 x5 -> valid=2'b01, active=2'b01, data_out[7:0]=8'h11.
